// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the SHA-256 digest output path.
package sha256_pkg;
    localparam int DIGEST_W     = 256;
    localparam int DIGEST_BYTES = 32;
    localparam int HEX_CHARS    = 64;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic [1:0] {SER_IDLE, SER_SEND, SER_DONE} ser_state_t;
endpackage

// File: rtl/hex_nibble_ascii.sv
// Maps one 4-bit nibble to its lowercase ASCII hex character.
module hex_nibble_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);
    assign ascii = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h57 + {4'h0, nibble});
endmodule

// File: rtl/sha256_digest_serializer.sv
// Captures a SHA-256 digest on the rising edge of hash_rdy and streams it out MSB-first
// as raw bytes or lowercase hex characters, optionally followed by CR/LF.
//  state    | meaning
//  SER_IDLE | waiting for a new digest
//  SER_SEND | presenting tx_data, advancing on each accepted byte
//  SER_DONE | one-cycle done pulse, then back to idle
module sha256_digest_serializer
    import sha256_pkg::*;
#(
    parameter bit HEX_ASCII      = 1'b1,
    parameter bit APPEND_NEWLINE = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hash_rdy,
    input  logic [DIGEST_W-1:0] hash_val,
    input  logic                tx_ready,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    output logic                busy,
    output logic                done,
    output logic                overrun
);
    localparam int DIG_LEN = HEX_ASCII ? HEX_CHARS : DIGEST_BYTES;
    localparam int N_CHARS = DIG_LEN + (APPEND_NEWLINE ? 2 : 0);
    localparam int SHIFT   = HEX_ASCII ? 4 : 8;
    localparam logic [6:0] LAST_IDX = 7'(N_CHARS - 1);
    localparam logic [6:0] DIG_IDX  = 7'(DIG_LEN);

    ser_state_t          state_q, state_d;
    logic [DIGEST_W-1:0] shreg_q, shreg_d;
    logic [6:0]          count_q, count_d;
    logic                hash_rdy_q;
    logic                overrun_q, overrun_d;
    logic                tx_valid_q, tx_valid_d;
    logic                done_q, done_d;
    logic                start, xfer, in_trailer;
    logic [7:0]          hex_char;

    hex_nibble_ascii u_hex (
        .nibble (shreg_q[DIGEST_W-1 -: 4]),
        .ascii  (hex_char)
    );

    assign start      = hash_rdy & ~hash_rdy_q;
    assign xfer       = tx_valid_q & tx_ready;
    assign in_trailer = (count_q >= DIG_IDX);

    // hash_rdy_q resets high so a level held through reset is not taken as a new digest
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SER_IDLE;
            shreg_q    <= '0;
            count_q    <= '0;
            hash_rdy_q <= 1'b1;
            overrun_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            count_q    <= count_d;
            hash_rdy_q <= hash_rdy;
            overrun_q  <= overrun_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        count_d    = count_q;
        overrun_d  = overrun_q;
        tx_valid_d = tx_valid_q;
        done_d     = 1'b0;
        case (state_q)
            SER_IDLE: begin
                if (start) begin
                    shreg_d    = hash_val;
                    count_d    = '0;
                    tx_valid_d = 1'b1;
                    state_d    = SER_SEND;
                end
            end
            SER_SEND: begin
                if (start) overrun_d = 1'b1;
                if (xfer) begin
                    if (count_q == LAST_IDX) begin
                        count_d    = '0;
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = SER_DONE;
                    end else begin
                        count_d = count_q + 7'd1;
                        if (!in_trailer) shreg_d = shreg_q << SHIFT;
                    end
                end
            end
            SER_DONE: begin
                if (start) overrun_d = 1'b1;
                state_d = SER_IDLE;
            end
            default: state_d = SER_IDLE;
        endcase
    end

    always_comb begin
        tx_data = '0;
        if (state_q == SER_SEND) begin
            if (in_trailer)     tx_data = (count_q == DIG_IDX) ? CHAR_CR : CHAR_LF;
            else if (HEX_ASCII) tx_data = hex_char;
            else                tx_data = shreg_q[DIGEST_W-1 -: 8];
        end
    end

    assign tx_valid = tx_valid_q;
    assign busy     = (state_q != SER_IDLE);
    assign done     = done_q;
    assign overrun  = overrun_q;
endmodule
